// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared mode encodings and channel-index helper for mux_n_1_rr
package mux_pkg;

    localparam logic MODE_SEL = 1'b0;
    localparam logic MODE_RR  = 1'b1;

    // Next channel after idx, wrapping explicitly so non-power-of-2 counts work
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx == n - 1) ? 32'd0 : idx + 32'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - rotating-priority encoder: first request at or after ptr, wrapping
module rr_pick #(
    parameter int N  = 8,
    parameter int SW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic          gnt_v,
    output logic [SW-1:0] g
);

    logic [N-1:0] upper;

    // Lowest request at or above ptr wins; otherwise fall back to the lowest overall
    always_comb begin
        upper = '0;
        g     = '0;
        for (int i = 0; i < N; i++) begin
            upper[i] = req[i] && (SW'(i) >= ptr);
        end
        gnt_v = |req;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) g = SW'(i);
        end
        if (|upper) begin
            for (int i = N - 1; i >= 0; i--) begin
                if (upper[i]) g = SW'(i);
            end
        end
    end

endmodule

// File: rtl/mux_n_1_rr.sv
// rtl/mux_n_1_rr.sv - N:1 registered mux with valid/ready, direct-select or round-robin
module mux_n_1_rr
    import mux_pkg::*;
#(
    parameter  int N  = 8,
    parameter  int W  = 3,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [SW-1:0]  s,
    input  logic [N*W-1:0] d,
    input  logic [N-1:0]   d_valid,
    output logic [N-1:0]   d_ready,
    output logic [W-1:0]   y,
    output logic           y_valid,
    input  logic           y_ready,
    output logic [SW-1:0]  y_ch
);

    logic          load;
    logic          sel_valid;
    logic          rr_gnt_v;
    logic [SW-1:0] rr_g;
    logic          gnt_v;
    logic [SW-1:0] g;
    logic [W-1:0]  g_data;
    logic [SW-1:0] ptr;

    rr_pick #(.N(N), .SW(SW)) u_rr_pick (
        .req   (d_valid),
        .ptr   (ptr),
        .gnt_v (rr_gnt_v),
        .g     (rr_g)
    );

    assign load = !y_valid || y_ready;

    // An out-of-range s matches no channel, so it never grants
    always_comb begin
        sel_valid = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (s == SW'(i)) sel_valid = d_valid[i];
        end
    end

    always_comb begin
        if (mode == MODE_RR) begin
            gnt_v = rr_gnt_v;
            g     = rr_g;
        end else begin
            gnt_v = sel_valid;
            g     = s;
        end
    end

    always_comb begin
        g_data  = '0;
        d_ready = '0;
        for (int i = 0; i < N; i++) begin
            if (g == SW'(i)) g_data = d[i*W +: W];
            d_ready[i] = rst_n && load && gnt_v && (g == SW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y       <= '0;
            y_valid <= 1'b0;
            y_ch    <= '0;
            ptr     <= '0;
        end else if (load) begin
            y_valid <= gnt_v;
            if (gnt_v) begin
                y    <= g_data;
                y_ch <= g;
                ptr  <= SW'(wrap_inc(32'(g), N));
            end
        end
    end

endmodule

// File: tb/tb_mux_n_1_rr.sv
// tb/tb_mux_n_1_rr.sv - directed self-checking bench for mux_n_1_rr (N=8 and N=5)
module tb_mux_n_1_rr;

    logic        clk = 1'b0;
    logic        rst_n;
    int          checks = 0;
    int          errors = 0;

    logic        mode8, yr8, yv8;
    logic [2:0]  s8, y8, ych8;
    logic [23:0] d8;
    logic [7:0]  dv8, dr8;

    logic        mode5, yr5, yv5;
    logic [2:0]  s5, y5, ych5;
    logic [14:0] d5;
    logic [4:0]  dv5, dr5;

    always #5 clk = ~clk;

    mux_n_1_rr #(.N(8), .W(3)) u8 (
        .clk(clk), .rst_n(rst_n), .mode(mode8), .s(s8), .d(d8), .d_valid(dv8),
        .d_ready(dr8), .y(y8), .y_valid(yv8), .y_ready(yr8), .y_ch(ych8)
    );

    mux_n_1_rr #(.N(5), .W(3)) u5 (
        .clk(clk), .rst_n(rst_n), .mode(mode5), .s(s5), .d(d5), .d_valid(dv5),
        .d_ready(dr5), .y(y5), .y_valid(yv5), .y_ready(yr5), .y_ch(ych5)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        mode8 = 1'b0; s8 = 3'd5; dv8 = 8'hFF; yr8 = 1'b1; d8 = '0;
        mode5 = 1'b0; s5 = 3'd0; dv5 = 5'h00; yr5 = 1'b1; d5 = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dr8 !== 8'h00) begin
            errors++; $display("FAIL rst_dready_held: got %b expected %b", dr8, 8'h00);
        end
        dv8 = 8'h00;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({y8, yv8, ych8, dr8} !== 15'd0) begin
                errors++;
                $display("FAIL idle_%0d: got y=%0d v=%b ch=%0d rdy=%b expected all zero", k, y8, yv8, ych8, dr8);
            end
        end
    endtask

    task automatic test_direct_select();
        do_reset();
        for (int i = 0; i < 8; i++) d8[i*3 +: 3] = 3'(i);
        mode8 = 1'b0; s8 = 3'd5; dv8 = 8'hFF; yr8 = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (dr8 !== 8'b0010_0000) begin
                errors++; $display("FAIL ds_ready_%0d: got %b expected %b", k, dr8, 8'b0010_0000);
            end
            tick();
            checks++;
            if (yv8 !== 1'b1 || y8 !== 3'd5 || ych8 !== 3'd5) begin
                errors++; $display("FAIL ds_out_%0d: got v=%b y=%0d ch=%0d expected v=1 y=5 ch=5", k, yv8, y8, ych8);
            end
        end
    endtask

    task automatic test_rr_fairness();
        logic [2:0] exp_ch [6] = '{3'd1, 3'd4, 3'd7, 3'd1, 3'd4, 3'd7};
        logic [7:0] exp_rdy;
        do_reset();
        for (int i = 0; i < 8; i++) d8[i*3 +: 3] = 3'(i);
        mode8 = 1'b1; dv8 = 8'b1001_0010; yr8 = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            exp_rdy = 8'd1 << exp_ch[k];
            checks++;
            if (dr8 !== exp_rdy) begin
                errors++; $display("FAIL rr_ready_%0d: got %b expected %b", k, dr8, exp_rdy);
            end
            tick();
            checks++;
            if (yv8 !== 1'b1 || ych8 !== exp_ch[k] || y8 !== exp_ch[k]) begin
                errors++; $display("FAIL rr_out_%0d: got v=%b ch=%0d y=%0d expected v=1 ch=%0d", k, yv8, ych8, y8, exp_ch[k]);
            end
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        for (int i = 0; i < 8; i++) d8[i*3 +: 3] = 3'(7 - i);
        mode8 = 1'b1; dv8 = 8'hFF; yr8 = 1'b1;
        #1;
        checks++;
        if (dr8 !== 8'b0000_0001) begin
            errors++; $display("FAIL bp_first_ready: got %b expected %b", dr8, 8'b0000_0001);
        end
        tick();
        yr8 = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (yv8 !== 1'b1 || ych8 !== 3'd0 || y8 !== 3'd7 || dr8 !== 8'h00) begin
                errors++;
                $display("FAIL bp_stall_%0d: got v=%b ch=%0d y=%0d rdy=%b expected v=1 ch=0 y=7 rdy=0", k, yv8, ych8, y8, dr8);
            end
            tick();
        end
        checks++;
        if (yv8 !== 1'b1 || ych8 !== 3'd0 || y8 !== 3'd7) begin
            errors++; $display("FAIL bp_stall_end: got v=%b ch=%0d y=%0d expected v=1 ch=0 y=7", yv8, ych8, y8);
        end
        yr8 = 1'b1;
        #1;
        checks++;
        if (dr8 !== 8'b0000_0010) begin
            errors++; $display("FAIL bp_release_ready: got %b expected %b", dr8, 8'b0000_0010);
        end
        tick();
        checks++;
        if (yv8 !== 1'b1 || ych8 !== 3'd1 || y8 !== 3'd6) begin
            errors++; $display("FAIL bp_after_1: got v=%b ch=%0d y=%0d expected v=1 ch=1 y=6", yv8, ych8, y8);
        end
        tick();
        checks++;
        if (yv8 !== 1'b1 || ych8 !== 3'd2 || y8 !== 3'd5) begin
            errors++; $display("FAIL bp_after_2: got v=%b ch=%0d y=%0d expected v=1 ch=2 y=5", yv8, ych8, y8);
        end
        dv8 = 8'h00;
        tick();
        checks++;
        if (yv8 !== 1'b0) begin
            errors++; $display("FAIL bp_drain_empty: got v=%b expected v=0", yv8);
        end
    endtask

    task automatic test_non_pow2();
        logic [2:0] exp_ch [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        logic [4:0] exp_rdy;
        do_reset();
        for (int i = 0; i < 5; i++) d5[i*3 +: 3] = 3'(i + 1);
        mode5 = 1'b0; s5 = 3'd6; dv5 = 5'h1F; yr5 = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (dr5 !== 5'h00) begin
                errors++; $display("FAIL np2_bad_sel_ready_%0d: got %b expected %b", k, dr5, 5'h00);
            end
            tick();
            checks++;
            if (yv5 !== 1'b0) begin
                errors++; $display("FAIL np2_bad_sel_valid_%0d: got %b expected 0", k, yv5);
            end
        end
        mode5 = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            exp_rdy = 5'd1 << exp_ch[k];
            checks++;
            if (dr5 !== exp_rdy) begin
                errors++; $display("FAIL np2_rr_ready_%0d: got %b expected %b", k, dr5, exp_rdy);
            end
            tick();
            checks++;
            if (yv5 !== 1'b1 || ych5 !== exp_ch[k] || y5 !== 3'(exp_ch[k] + 1)) begin
                errors++; $display("FAIL np2_rr_out_%0d: got v=%b ch=%0d y=%0d expected v=1 ch=%0d", k, yv5, ych5, y5, exp_ch[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 8; i++) d8[i*3 +: 3] = 3'(i);
        mode8 = 1'b1; dv8 = 8'hFF; yr8 = 1'b1;
        tick();
        tick();
        checks++;
        if (yv8 !== 1'b1 || ych8 !== 3'd1) begin
            errors++; $display("FAIL ar_pre: got v=%b ch=%0d expected v=1 ch=1", yv8, ych8);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (yv8 !== 1'b0 || ych8 !== 3'd0 || y8 !== 3'd0 || dr8 !== 8'h00) begin
            errors++; $display("FAIL ar_drop: got v=%b ch=%0d y=%0d rdy=%b expected all zero", yv8, ych8, y8, dr8);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        dv8 = 8'b0110_0000;
        #1;
        checks++;
        if (dr8 !== 8'b0010_0000) begin
            errors++; $display("FAIL ar_first_ready: got %b expected %b", dr8, 8'b0010_0000);
        end
        tick();
        checks++;
        if (yv8 !== 1'b1 || ych8 !== 3'd5 || y8 !== 3'd5) begin
            errors++; $display("FAIL ar_first_out: got v=%b ch=%0d y=%0d expected v=1 ch=5 y=5", yv8, ych8, y8);
        end
        dv8 = 8'b0000_1000;
        #1;
        checks++;
        if (dr8 !== 8'b0000_1000) begin
            errors++; $display("FAIL ar_wrap_ready: got %b expected %b", dr8, 8'b0000_1000);
        end
        tick();
        checks++;
        if (yv8 !== 1'b1 || ych8 !== 3'd3) begin
            errors++; $display("FAIL ar_wrap_out: got v=%b ch=%0d expected v=1 ch=3", yv8, ych8);
        end
    endtask

    initial begin
        test_reset();
        test_direct_select();
        test_rr_fairness();
        test_back_pressure();
        test_non_pow2();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux_n_1_rr.md
Name: mux_n_1_rr

Overview:
- Parametrised N-channel, W-bit multiplexer with a registered output and valid/ready flow control on every input and on the output.
- Two selection modes:
  - Direct-select (mode 0): channel chosen by `s`, the same role `s` plays in the existing combinational muxes.
  - Round-robin (mode 1): the block picks the next valid channel itself.
- Sits between several producer channels and one consumer. It replaces the fixed 4:1/8:1 combinational muxes wherever back-pressure or fair sharing is needed.

Parameters:
- N, 8, number of input channels (2..32).
- W, 3, data width per channel in bits (>=1).
- SW, $clog2(N), select/channel-index width; localparam, derived, not overridable.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = direct-select by s, 1 = round-robin.
- s  input  SW  channel select, used only when mode = 0.
- d  input  N*W  flattened channel data; channel i occupies d[i*W +: W].
- d_valid  input  N  per-channel valid; bit i belongs to channel i.
- d_ready  output  N  per-channel ready (combinational); bit i belongs to channel i.
- y  output  W  registered output data.
- y_valid  output  1  output valid (registered).
- y_ready  input  1  consumer ready.
- y_ch  output  SW  index of the channel that supplied y (registered).

Behaviour:
- Reset (rst_n low, asynchronous): y = 0, y_valid = 0, y_ch = 0, rr pointer ptr = 0. d_ready = 0 while rst_n is low.
- load = !y_valid || y_ready. The output register may be written this cycle only when load is 1.
- Grant, mode 0: gnt_v = d_valid[s] and (s < N); g = s.
- Grant, mode 1:
  - g is the first i with d_valid[i] set, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - gnt_v = |d_valid.
- d_ready[i] = load && gnt_v && (g == i). At most one bit is high at a time. d_ready never depends on d_valid of other channels in mode 0.
- Transfer on channel i: d_valid[i] && d_ready[i] at the clock edge. Next cycle: y = d[g], y_ch = g, y_valid = 1. Latency is exactly 1 cycle from input handshake to y_valid.
- Pointer update: ptr = (g == N-1) ? 0 : g+1. This applies on every transfer in either mode, so round-robin resumes fairly after a mode switch. Wrap from N-1 to 0 is explicit and correct for non-power-of-2 N.
- load && !gnt_v: y_valid goes to 0 next cycle. y and y_ch hold their old values (don't-care).
- y_valid && !y_ready (stall):
  - y, y_ch and y_valid hold stable.
  - All d_ready are 0.
  - ptr does not change.
- Simultaneous output drain and input accept (y_valid && y_ready && gnt_v): the new word is loaded in the same cycle. This gives full throughput of one word per clock with no bubble.
- Changes to mode or s take effect combinationally in the current cycle's grant. Changing them while stalled has no effect until load = 1.
- s >= N (non-power-of-2 N) in mode 0: no grant, no transfer, all d_ready = 0.
- Reset asserted mid-transfer: the output word is discarded, y_valid drops immediately, and ptr returns to 0.
- No combinational path from d to y. There is a combinational path from y_ready, d_valid, mode and s to d_ready.

Decomposition:
- Package mux_pkg:
  - MODE_SEL = 1'b0 and MODE_RR = 1'b1.
  - A helper function for wrapped increment of a channel index.
- One sub-module, rr_pick (params N, SW): inputs req[N-1:0] and ptr; outputs gnt_v and g. It implements the rotating-priority encoder, e.g. a doubled request vector with masked priority. mux_n_1_rr holds the registers, the handshake logic and the mode select.

Test Plan:
- Reset and idle: with N=8 and W=3, hold rst_n = 0, then release it with all d_valid = 0 -> y = 0, y_valid = 0, y_ch = 0, and d_ready = 0 for 5 cycles.
- Direct select: mode = 0, s = 5, d_valid = 8'hFF, channel i data = i, y_ready = 1 -> d_ready = 8'b0010_0000 every cycle. y = 3'd5 and y_ch = 5 from the second cycle onward, one word per clock.
- Round-robin fairness: mode = 1, d_valid = 8'b1001_0010, y_ready = 1 -> y_ch sequence 1, 4, 7, 1, 4, 7, ... with no gaps. After channel 7 the pointer wraps to 0.
- Back-pressure: mode = 1, all valid, y_ready = 0 for 3 cycles after the first word (y_ch = 0) -> y, y_ch and y_valid stable and d_ready = 0 during the stall. On release, y_ch advances to 1, with no word lost or duplicated.
- Non-power-of-2 with bad select: N = 5, mode = 0, s = 6, all valid -> d_ready = 0 and y_valid = 0. Switching to mode = 1 gives y_ch sequence 0, 1, 2, 3, 4, 0.
- Async reset mid-stream: assert rst_n low between clock edges while y_valid = 1 -> y_valid = 0 immediately. After release, the first round-robin grant is the lowest valid channel from index 0.
